// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue unit.
// Optional divide/modulus-by-zero trapping is enabled by ALU_ISSUE_DIVZERO_CHECK_EN.
package alu_pkg;

    localparam int OPERAND_W = 4;
    localparam int RESULT_W  = 8;
    localparam int CMD_W     = 3 * OPERAND_W;

    localparam logic [OPERAND_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OPERAND_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OPERAND_W-1:0] OP_AND = 4'b0010;
    localparam logic [OPERAND_W-1:0] OP_OR  = 4'b0011;
    localparam logic [OPERAND_W-1:0] OP_XOR = 4'b0100;
    localparam logic [OPERAND_W-1:0] OP_NOT = 4'b0101;
    localparam logic [OPERAND_W-1:0] OP_SHL = 4'b0110;
    localparam logic [OPERAND_W-1:0] OP_SHR = 4'b0111;
    localparam logic [OPERAND_W-1:0] OP_MUL = 4'b1000;
    localparam logic [OPERAND_W-1:0] OP_DIV = 4'b1001;
    localparam logic [OPERAND_W-1:0] OP_MOD = 4'b1010;
    localparam logic [OPERAND_W-1:0] OP_LT  = 4'b1011;
    localparam logic [OPERAND_W-1:0] OP_EQ  = 4'b1100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [OPERAND_W-1:0] sel;
        logic [OPERAND_W-1:0] a;
        logic [OPERAND_W-1:0] b;
    } cmd_t;

    function automatic logic is_div_op(input logic [OPERAND_W-1:0] sel);
        return (sel == OP_DIV) || (sel == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU issue unit; DEPTH must be a power of two.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Queues ALU commands, issues them to an external ALU and holds each response until accepted.
// Define ALU_ISSUE_DIVZERO_CHECK_EN to trap divide/modulus by zero into rsp_err.
//
// state | meaning
// IDLE  | no command in flight, waiting for FIFO data
// DRIVE | operands on the ALU bus, result captured at the end of this cycle
// RESP  | response held until rsp_ready
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [OPERAND_W-1:0] cmd_a,
    input  logic [OPERAND_W-1:0] cmd_b,
    input  logic [OPERAND_W-1:0] cmd_sel,
    output logic [OPERAND_W-1:0] alu_a,
    output logic [OPERAND_W-1:0] alu_b,
    output logic [OPERAND_W-1:0] alu_sel,
    input  logic [RESULT_W-1:0]  alu_out,
    input  logic                 alu_carry,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [RESULT_W-1:0]  rsp_data,
    output logic                 rsp_carry,
    output logic                 rsp_err
);

    state_t               state_q, state_d;
    logic [OPERAND_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_sel_q, alu_sel_d;
    logic [RESULT_W-1:0]  rsp_data_q, rsp_data_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_carry_q, rsp_carry_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 fifo_full, fifo_empty, fifo_pop;
    logic [CMD_W-1:0]     fifo_head;
    cmd_t                 head_cmd;

    assign cmd_ready = !fifo_full && !rst;
    assign head_cmd  = cmd_t'(fifo_head);

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .pop   (fifo_pop),
        .din   ({cmd_sel, cmd_a, cmd_b}),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_err_d   = rsp_err_q;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    alu_a_d   = head_cmd.a;
                    alu_b_d   = head_cmd.b;
                    alu_sel_d = head_cmd.sel;
                    state_d   = DRIVE;
                end
            end
            DRIVE: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = alu_out;
                rsp_carry_d = alu_carry;
                rsp_err_d   = 1'b0;
`ifdef ALU_ISSUE_DIVZERO_CHECK_EN
                if (is_div_op(alu_sel_q) && (alu_b_q == '0)) begin
                    rsp_data_d  = '0;
                    rsp_carry_d = 1'b0;
                    rsp_err_d   = 1'b1;
                end
`endif
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        alu_a_d   = head_cmd.a;
                        alu_b_d   = head_cmd.b;
                        alu_sel_d = head_cmd.sel;
                        state_d   = DRIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
`ifdef ALU_ISSUE_DIVZERO_CHECK_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule
